// File: rtl/prog_loader_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | prog_loader_if: byte stream in, word-write bus out, for loader   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_byte,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_byte,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | prog_loader: assembles a byte-serial framed image into 32-bit    |
// | words, writes them from BASE_ADDR, then releases the processor.   |
// | Optional trailing XOR checksum: PROG_LOADER_CKSUM_EN              |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module prog_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  wire          clk1,
  input  wire          rst_n,
  prog_loader_if.slave bus,
  output logic         cpu_run,
  output logic         busy,
  output logic         err
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_HI = 3'd1,
    S_CNT_LO = 3'd2,
    S_DATA   = 3'd3,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
`ifdef PROG_LOADER_CKSUM_EN
    , S_CKSUM = 3'd4
`endif
  } state_t;

`ifdef PROG_LOADER_CKSUM_EN
  localparam state_t S_AFTER_LOAD = S_CKSUM;
`else
  localparam state_t S_AFTER_LOAD = S_DONE;
`endif

  state_t            state;
  state_t            state_nxt;
  logic              ready;
  logic              accept;
  logic              word_done;
  logic [15:0]       count_word;
  logic [7:0]        count_hi;
  logic [15:0]       words_left;
  logic [1:0]        byte_cnt;
  logic [23:0]       shreg;
  logic [ADDR_W-1:0] next_addr;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0]        cksum;
`endif

  assign accept     = bus.in_valid & ready;
  assign count_word = {count_hi, bus.in_byte};
  assign word_done  = accept && (state == S_DATA) && (byte_cnt == 2'd3);

  assign bus.in_ready  = ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    err       = 1'b0;
    cpu_run   = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (accept && (bus.in_byte == SYNC_BYTE)) begin
          state_nxt = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (accept) begin
          state_nxt = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (accept) begin
          if (32'(count_word) > MAX_WORDS) begin
            state_nxt = S_ERR;
          end else if (count_word == 16'd0) begin
            state_nxt = S_AFTER_LOAD;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (word_done && (words_left == 16'd1)) begin
          state_nxt = S_AFTER_LOAD;
        end
      end
`ifdef PROG_LOADER_CKSUM_EN
      S_CKSUM: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (accept) begin
          state_nxt = (bus.in_byte == cksum) ? S_DONE : S_ERR;
        end
      end
`endif
      // The final write strobe may still be in flight on entry; release after it.
      S_DONE: begin
        cpu_run = ~mem_we_q;
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      count_hi    <= 8'd0;
      words_left  <= 16'd0;
      byte_cnt    <= 2'd0;
      shreg       <= 24'd0;
      next_addr   <= ADDR_W'(BASE_ADDR);
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
`ifdef PROG_LOADER_CKSUM_EN
      cksum       <= 8'd0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      if (accept) begin
        case (state)
          S_IDLE: begin
            if (bus.in_byte == SYNC_BYTE) begin
              byte_cnt  <= 2'd0;
              next_addr <= ADDR_W'(BASE_ADDR);
`ifdef PROG_LOADER_CKSUM_EN
              cksum     <= 8'd0;
`endif
            end
          end
          S_CNT_HI: count_hi   <= bus.in_byte;
          S_CNT_LO: words_left <= count_word;
          S_DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= {shreg[15:0], bus.in_byte};
`ifdef PROG_LOADER_CKSUM_EN
            cksum    <= cksum ^ bus.in_byte;
`endif
            if (byte_cnt == 2'd3) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= next_addr;
              mem_wdata_q <= {shreg, bus.in_byte};
              next_addr   <= next_addr + ADDR_W'(1);
              words_left  <= words_left - 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
